mem_write_arbiter: RTL and testbench

MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

---
 rtl/hack_mem_pkg.sv | 25 ++
 rtl/demux_1x2.sv | 12 +
 rtl/mem_write_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_write_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the Hack memory write path.
// Address map: RAM16K below SCREEN_BASE, Screen up to KBD_ADDR, keyboard/unmapped above.
package hack_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int N_REQ  = 2;
    localparam int CNT_W  = 8;

    localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    function automatic logic is_writable(addr_t a);
        return a < KBD_ADDR;
    endfunction

endpackage

// File: rtl/demux_1x2.sv
// One-to-two demultiplexer: y_in routed to a_out when sel_in is 0, b_out when 1.
module demux_1x2 (
    input  logic y_in,
    input  logic sel_in,
    output logic a_out,
    output logic b_out
);

    assign a_out = y_in & ~sel_in;
    assign b_out = y_in & sel_in;

endmodule

// File: rtl/mem_write_arbiter.sv
// Round-robin write arbiter between CPU and DMA in front of RAM16K/Screen.
// One write in flight; issue phase ends on ack or after a bounded wait.
module mem_write_arbiter
    import hack_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [N_REQ-1:0]             req_valid_in,
    input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr_in,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_data_in,
    output logic [N_REQ-1:0]             req_ready_out,
    output logic [ADDR_W-1:0]            wr_addr_out,
    output logic [DATA_W-1:0]            wr_data_out,
    output logic                         ram_load_out,
    output logic                         screen_load_out,
    input  logic                         wr_ack_in,
    output logic                         err_illegal_out,
    output logic                         err_timeout_out
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q;
    state_t           state_d;
    logic             ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             gnt_idx;
    logic [N_REQ-1:0] gnt_vec;
    logic             accept;
    logic             mapped;
    logic             issue_active;
    logic             ack_hit;
    logic             expire;

    // ptr_q names the preferred requester on contention (0 = CPU)
    always_comb begin
        gnt_idx = ptr_q;
        unique case (req_valid_in)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            default: gnt_idx = ptr_q;
        endcase
    end

    always_comb begin
        gnt_vec = '0;
        if (state_q == IDLE && !rst_in && req_valid_in[gnt_idx]) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign req_ready_out = gnt_vec;
    assign accept        = |gnt_vec;
    assign mapped        = is_writable(req_addr_in[gnt_idx]);
    assign issue_active  = (state_q == ISSUE);
    assign ack_hit       = issue_active && wr_ack_in;
    assign expire        = issue_active && !wr_ack_in
                           && (cnt_q + CNT_W'(1) == TO_LIM);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && mapped) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_hit || expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_q           <= 1'b0;
            cnt_q           <= '0;
            wr_addr_out     <= '0;
            wr_data_out     <= '0;
            err_illegal_out <= 1'b0;
            err_timeout_out <= 1'b0;
        end else begin
            err_illegal_out <= 1'b0;
            err_timeout_out <= 1'b0;
            if (accept) begin
                wr_addr_out     <= req_addr_in[gnt_idx];
                wr_data_out     <= req_data_in[gnt_idx];
                ptr_q           <= ~gnt_idx;
                cnt_q           <= '0;
                err_illegal_out <= ~mapped;
            end
            if (issue_active) begin
                if (ack_hit || expire) begin
                    cnt_q           <= '0;
                    err_timeout_out <= expire;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    demux_1x2 u_strobe (
        .y_in   (issue_active),
        .sel_in (wr_addr_out[14]),
        .a_out  (ram_load_out),
        .b_out  (screen_load_out)
    );

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Scenario bench for mem_write_arbiter with a scoreboard of expected writes.
// Inputs change 2 time units after the rising edge; outputs are sampled there too.
module tb_mem_write_arbiter;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
        logic        ram;
        logic        scr;
        logic        ill;
    } exp_t;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [1:0]       req_valid_in;
    logic [1:0][14:0] req_addr_in;
    logic [1:0][15:0] req_data_in;
    logic [1:0]       req_ready_out;
    logic [14:0]      wr_addr_out;
    logic [15:0]      wr_data_out;
    logic             ram_load_out;
    logic             screen_load_out;
    logic             wr_ack_in;
    logic             err_illegal_out;
    logic             err_timeout_out;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic exp_ptr;

    mem_write_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_valid_in    (req_valid_in),
        .req_addr_in     (req_addr_in),
        .req_data_in     (req_data_in),
        .req_ready_out   (req_ready_out),
        .wr_addr_out     (wr_addr_out),
        .wr_data_out     (wr_data_out),
        .ram_load_out    (ram_load_out),
        .screen_load_out (screen_load_out),
        .wr_ack_in       (wr_ack_in),
        .err_illegal_out (err_illegal_out),
        .err_timeout_out (err_timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step;
        @(posedge clk_in);
        #2;
    endtask

    function automatic exp_t mk(logic [14:0] a, logic [15:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.ill  = (a >= 15'h6000);
        e.ram  = (a < 15'h4000);
        e.scr  = (a >= 15'h4000) && (a < 15'h6000);
        return e;
    endfunction

    task automatic test_reset;
        rst_in = 1'b1;
        req_valid_in = 2'b11;
        step;
        step;
        #1;
        total++;
        if (req_ready_out !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=00", req_ready_out);
        end
        total++;
        if ({wr_addr_out, wr_data_out, ram_load_out, screen_load_out,
             err_illegal_out, err_timeout_out} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outs got=%h/%h %b%b%b%b exp=0",
                     wr_addr_out, wr_data_out, ram_load_out,
                     screen_load_out, err_illegal_out, err_timeout_out);
        end
        rst_in = 1'b0;
        #1;
        total++;
        if (req_ready_out !== 2'b01) begin
            bad++;
            $display("FAIL reset_ptr got=%b exp=01", req_ready_out);
        end
        req_valid_in = 2'b00;
        exp_ptr = 1'b0;
        step;
    endtask

    task automatic test_round_robin;
        exp_t e;
        int   grants[2];
        logic g;
        grants[0] = 0;
        grants[1] = 0;
        req_addr_in[0] = 15'h0020;
        req_data_in[0] = 16'h1000;
        req_addr_in[1] = 15'h4100;
        req_data_in[1] = 16'h2000;
        req_valid_in = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (req_ready_out !== (exp_ptr ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL rr_grant%0d got=%b exp_ptr=%b",
                         i, req_ready_out, exp_ptr);
            end
            g = exp_ptr;
            sb.push_back(mk(req_addr_in[g], req_data_in[g]));
            grants[g]++;
            exp_ptr = ~g;
            step;
            req_addr_in[g] = req_addr_in[g] + 15'd1;
            req_data_in[g] = req_data_in[g] + 16'd1;
            #1;
            total++;
            if (req_ready_out !== 2'b00) begin
                bad++;
                $display("FAIL rr_issue_ready%0d got=%b exp=00",
                         i, req_ready_out);
            end
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rr_sb_empty%0d", i);
            end else begin
                e = sb.pop_front();
                total++;
                if ({wr_addr_out, wr_data_out, ram_load_out,
                     screen_load_out, err_illegal_out}
                    !== {e.addr, e.data, e.ram, e.scr, e.ill}) begin
                    bad++;
                    $display("FAIL rr_write%0d got=%h/%h %b%b%b exp=%h/%h %b%b%b",
                             i, wr_addr_out, wr_data_out, ram_load_out,
                             screen_load_out, err_illegal_out,
                             e.addr, e.data, e.ram, e.scr, e.ill);
                end
            end
            wr_ack_in = 1'b1;
            step;
            wr_ack_in = 1'b0;
        end
        req_valid_in = 2'b00;
        total++;
        if (grants[0] != 2 || grants[1] != 2) begin
            bad++;
            $display("FAIL rr_fair got=%0d/%0d exp=2/2", grants[0], grants[1]);
        end
        step;
    endtask

    task automatic test_cpu_single;
        exp_t e;
        req_valid_in = 2'b01;
        req_addr_in[0] = 15'h0010;
        req_data_in[0] = 16'hBEEF;
        #1;
        total++;
        if (req_ready_out !== 2'b01) begin
            bad++;
            $display("FAIL cpu_ready got=%b exp=01", req_ready_out);
        end
        sb.push_back(mk(15'h0010, 16'hBEEF));
        exp_ptr = 1'b1;
        step;
        req_valid_in = 2'b00;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL cpu_sb_empty");
        end else begin
            e = sb.pop_front();
            for (int c = 1; c <= 3; c++) begin
                total++;
                if ({wr_addr_out, wr_data_out, ram_load_out, screen_load_out}
                    !== {e.addr, e.data, e.ram, e.scr}) begin
                    bad++;
                    $display("FAIL cpu_issue_c%0d got=%h/%h %b%b exp=%h/%h %b%b",
                             c, wr_addr_out, wr_data_out, ram_load_out,
                             screen_load_out, e.addr, e.data, e.ram, e.scr);
                end
                if (c == 3) wr_ack_in = 1'b1;
                step;
            end
        end
        wr_ack_in = 1'b0;
        total++;
        if ({ram_load_out, screen_load_out, err_timeout_out} !== 3'b000) begin
            bad++;
            $display("FAIL cpu_done got=%b%b%b exp=000",
                     ram_load_out, screen_load_out, err_timeout_out);
        end
    endtask

    task automatic test_screen;
        exp_t        e;
        logic [14:0] a;
        logic [15:0] d;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 15'h4000 : 15'h5FFF;
            d = (i == 0) ? 16'hFFFF : 16'h1234;
            req_valid_in = 2'b10;
            req_addr_in[1] = a;
            req_data_in[1] = d;
            #1;
            total++;
            if (req_ready_out !== 2'b10) begin
                bad++;
                $display("FAIL scr_ready%0d got=%b exp=10", i, req_ready_out);
            end
            sb.push_back(mk(a, d));
            exp_ptr = 1'b0;
            step;
            req_valid_in = 2'b00;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scr_sb_empty%0d", i);
            end else begin
                e = sb.pop_front();
                total++;
                if ({wr_addr_out, wr_data_out, ram_load_out, screen_load_out}
                    !== {e.addr, e.data, e.ram, e.scr}) begin
                    bad++;
                    $display("FAIL scr_write%0d got=%h/%h %b%b exp=%h/%h %b%b",
                             i, wr_addr_out, wr_data_out, ram_load_out,
                             screen_load_out, e.addr, e.data, e.ram, e.scr);
                end
            end
            wr_ack_in = 1'b1;
            step;
            wr_ack_in = 1'b0;
        end
    endtask

    task automatic test_illegal;
        exp_t e;
        req_valid_in = 2'b01;
        req_addr_in[0] = 15'h6000;
        req_data_in[0] = 16'hAAAA;
        #1;
        total++;
        if (req_ready_out !== 2'b01) begin
            bad++;
            $display("FAIL ill_ready got=%b exp=01", req_ready_out);
        end
        sb.push_back(mk(15'h6000, 16'hAAAA));
        exp_ptr = 1'b1;
        step;
        req_valid_in = 2'b00;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ill_sb_empty");
        end else begin
            e = sb.pop_front();
            total++;
            if ({wr_addr_out, wr_data_out, ram_load_out, screen_load_out,
                 err_illegal_out} !== {e.addr, e.data, e.ram, e.scr, e.ill}) begin
                bad++;
                $display("FAIL ill_pulse got=%h/%h %b%b%b exp=%h/%h %b%b%b",
                         wr_addr_out, wr_data_out, ram_load_out,
                         screen_load_out, err_illegal_out,
                         e.addr, e.data, e.ram, e.scr, e.ill);
            end
        end
        step;
        total++;
        if ({err_illegal_out, ram_load_out, screen_load_out} !== 3'b000) begin
            bad++;
            $display("FAIL ill_after got=%b%b%b exp=000",
                     err_illegal_out, ram_load_out, screen_load_out);
        end
        req_valid_in = 2'b11;
        #1;
        total++;
        if (req_ready_out !== (exp_ptr ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL ill_ptr got=%b exp_ptr=%b", req_ready_out, exp_ptr);
        end
        req_valid_in = 2'b00;
        step;
    endtask

    task automatic test_timeout;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            req_valid_in = 2'b01;
            req_addr_in[0] = (k == 0) ? 15'h0100 : 15'h0200;
            req_data_in[0] = (k == 0) ? 16'h5555 : 16'h6666;
            sb.push_back(mk(req_addr_in[0], req_data_in[0]));
            exp_ptr = 1'b1;
            step;
            req_valid_in = 2'b00;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL to_sb_empty%0d", k);
            end else begin
                e = sb.pop_front();
                total++;
                if ({wr_addr_out, wr_data_out} !== {e.addr, e.data}) begin
                    bad++;
                    $display("FAIL to_write%0d got=%h/%h exp=%h/%h",
                             k, wr_addr_out, wr_data_out, e.addr, e.data);
                end
            end
            for (int c = 1; c <= 4; c++) begin
                total++;
                if ({ram_load_out, err_timeout_out} !== 2'b10) begin
                    bad++;
                    $display("FAIL to_hold%0d_c%0d got=%b%b exp=10",
                             k, c, ram_load_out, err_timeout_out);
                end
                if (k == 1 && c == 4) wr_ack_in = 1'b1;
                step;
            end
            wr_ack_in = 1'b0;
            total++;
            if ({ram_load_out, screen_load_out, err_timeout_out}
                !== {2'b00, (k == 0)}) begin
                bad++;
                $display("FAIL to_end%0d got=%b%b%b exp_err=%0d",
                         k, ram_load_out, screen_load_out,
                         err_timeout_out, (k == 0));
            end
            step;
            total++;
            if (err_timeout_out !== 1'b0) begin
                bad++;
                $display("FAIL to_pulse%0d got=%b exp=0", k, err_timeout_out);
            end
        end
        wr_ack_in = 1'b1;
        step;
        wr_ack_in = 1'b0;
        total++;
        if ({ram_load_out, screen_load_out, err_illegal_out,
             err_timeout_out} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_ack got=%b%b%b%b exp=0000", ram_load_out,
                     screen_load_out, err_illegal_out, err_timeout_out);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        req_valid_in = 2'b10;
        req_addr_in[1] = 15'h4200;
        req_data_in[1] = 16'h7777;
        sb.push_back(mk(15'h4200, 16'h7777));
        step;
        req_valid_in = 2'b11;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rst_sb_empty");
        end else begin
            e = sb.pop_front();
            total++;
            if ({wr_addr_out, screen_load_out} !== {e.addr, e.scr}) begin
                bad++;
                $display("FAIL rst_write got=%h %b exp=%h %b",
                         wr_addr_out, screen_load_out, e.addr, e.scr);
            end
        end
        step;
        rst_in = 1'b1;
        step;
        #1;
        total++;
        if (req_ready_out !== 2'b00) begin
            bad++;
            $display("FAIL rst_ready got=%b exp=00", req_ready_out);
        end
        total++;
        if ({wr_addr_out, wr_data_out, ram_load_out, screen_load_out,
             err_illegal_out, err_timeout_out} !== 35'd0) begin
            bad++;
            $display("FAIL rst_outs got=%h/%h %b%b%b%b exp=0",
                     wr_addr_out, wr_data_out, ram_load_out,
                     screen_load_out, err_illegal_out, err_timeout_out);
        end
        rst_in = 1'b0;
        exp_ptr = 1'b0;
        #1;
        total++;
        if (req_ready_out !== 2'b01) begin
            bad++;
            $display("FAIL rst_ptr got=%b exp=01", req_ready_out);
        end
        req_valid_in = 2'b00;
        step;
        total++;
        if ({err_illegal_out, err_timeout_out,
             ram_load_out, screen_load_out} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_noerr got=%b%b%b%b exp=0000", err_illegal_out,
                     err_timeout_out, ram_load_out, screen_load_out);
        end
    endtask

    initial begin
        rst_in       = 1'b1;
        req_valid_in = 2'b00;
        req_addr_in  = '0;
        req_data_in  = '0;
        wr_ack_in    = 1'b0;
        exp_ptr      = 1'b0;
        test_reset;
        test_round_robin;
        test_cpu_single;
        test_screen;
        test_illegal;
        test_timeout;
        test_reset_mid;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
